// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three buses around the memory-port arbiter:
//     if_*  : instruction-fetch requester (32-bit read-only, word sized)
//     dm_*  : load/store requester (64-bit, byte/half/word/dword)
//     mem_* : single-ported unified memory macro
//   Modports:
//     master : the arbiter (drives gnt/rvalid/rdata/err and mem_* requests)
//     slave  : the surrounding logic (requesters and memory model)
interface mem_port_arbiter_if;
    // Fetch requester
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    // Load/store requester
    logic        dm_req;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [63:0] dm_rdata;
    logic        dm_err;

    // Memory macro
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata, dm_err,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (IF) and
//   load/store (DM). One transaction is outstanding at a time. On a tie the
//   DATA_PRIORITY side wins, except that IF is forced through after losing
//   STARVE_LIMIT arbitrations in a row. A BUSY access that sees no mem_ready
//   for TIMEOUT_CYCLES cycles is aborted and answered with err=1.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous, active-low
//     bus   : mem_port_arbiter_if.master (fetch, load/store and memory buses)
module mem_port_arbiter #(
    parameter int DATA_PRIORITY  = 1,   // 1: DM wins ties, 0: IF wins ties
    parameter int STARVE_LIMIT   = 4,   // 1..15
    parameter int TIMEOUT_CYCLES = 64   // 2..255
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);

    typedef enum logic { IDLE, BUSY }     state_t;
    typedef enum logic { OWN_IF, OWN_DM } owner_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_n;
    owner_t     owner;
    logic [3:0] starve_cnt, starve_cnt_n;
    logic [7:0] tmo_cnt;

    logic win_if, win_dm;   // arbitration result in IDLE
    logic done, tmo;        // BUSY termination: normal / aborted

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_n      = state;
        starve_cnt_n = starve_cnt;
        win_if       = 1'b0;
        win_dm       = 1'b0;
        done         = 1'b0;
        tmo          = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.if_req && bus.dm_req) begin
                    // Starved fetch overrides the static priority.
                    if (starve_cnt == STARVE_MAX || DATA_PRIORITY == 0)
                        win_if = 1'b1;
                    else
                        win_dm = 1'b1;
                end else if (bus.if_req) begin
                    win_if = 1'b1;
                end else if (bus.dm_req) begin
                    win_dm = 1'b1;
                end

                if (win_if || win_dm)
                    state_n = BUSY;

                // Only losses while fetch is actually waiting accumulate.
                if (win_if || (win_dm && !bus.if_req))
                    starve_cnt_n = '0;
                else if (win_dm && starve_cnt != STARVE_MAX)
                    starve_cnt_n = starve_cnt + 4'd1;
            end

            BUSY: begin
                // mem_ready on the threshold cycle still counts as completion.
                if (bus.mem_ready) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            starve_cnt    <= '0;
            tmo_cnt       <= '0;
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.if_err    <= 1'b0;
            bus.dm_gnt    <= 1'b0;
            bus.dm_rvalid <= 1'b0;
            bus.dm_rdata  <= '0;
            bus.dm_err    <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_size  <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_cnt_n;

            // Grant, rvalid and err are single-cycle pulses.
            bus.if_gnt    <= win_if;
            bus.dm_gnt    <= win_dm;
            bus.if_rvalid <= (done || tmo) && owner == OWN_IF;
            bus.dm_rvalid <= (done || tmo) && owner == OWN_DM;
            bus.if_err    <= tmo && owner == OWN_IF;
            bus.dm_err    <= tmo && owner == OWN_DM;

            if (win_if) begin
                owner         <= OWN_IF;
                tmo_cnt       <= '0;
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= 1'b0;
                bus.mem_size  <= 2'b10;
                bus.mem_addr  <= bus.if_addr;
                bus.mem_wdata <= '0;
            end else if (win_dm) begin
                owner         <= OWN_DM;
                tmo_cnt       <= '0;
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= bus.dm_we;
                bus.mem_size  <= bus.dm_size;
                bus.mem_addr  <= bus.dm_addr;
                bus.mem_wdata <= bus.dm_wdata;
            end else if (state == BUSY) begin
                tmo_cnt <= tmo_cnt + 8'd1;
                if (done || tmo)
                    bus.mem_req <= 1'b0;
            end

            // Response data changes only when a response is issued and
            // otherwise holds its last value.
            if (owner == OWN_IF) begin
                if (done)
                    bus.if_rdata <= bus.mem_rdata[31:0];
                else if (tmo)
                    bus.if_rdata <= '0;
            end else begin
                if (done && !bus.mem_we)
                    bus.dm_rdata <= bus.mem_rdata;
                else if (done || tmo)
                    bus.dm_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Scoreboard bench for mem_port_arbiter (DATA_PRIORITY=1, STARVE_LIMIT=4,
//   TIMEOUT_CYCLES=64). Stimulus pushes expected grants and responses into
//   queues; a monitor pops and compares whenever the DUT shows gnt or rvalid.
//   A memory responder answers mem_req after a fixed latency or never.
module tb_mem_port_arbiter;

    typedef struct {
        bit          is_dm;
        logic [63:0] addr;
        bit          we;
        logic [1:0]  size;
        logic [63:0] wdata;
    } gnt_t;

    typedef struct {
        bit          is_dm;
        bit          err;
        logic [63:0] rdata;
    } rsp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .DATA_PRIORITY (1),
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    gnt_t gq[$];
    rsp_t rq[$];

    int if_left  = 0;   // accesses the fetch requester still wants
    int dm_left  = 0;   // accesses the load/store requester still wants
    bit mem_hang = 1'b0;
    int mem_lat  = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Memory contents used by the responder; expected values are hand-written
    // into the stimulus below.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        case (a)
            64'h40:   return 64'hFFFF_FFFF_00A0_0093;
            64'h44:   return 64'h0000_0000_00B0_0113;
            64'h48:   return 64'h1234_5678_0000_0513;
            64'h1000: return 64'h1122_3344_5566_7788;
            64'h1008: return 64'h0F0E_0D0C_0B0A_0908;
            default:  return 64'hDEAD_0000_0000_0000;
        endcase
    endfunction

    // Memory responder: ready for one cycle on the mem_lat-th BUSY cycle.
    initial begin
        int mcnt;
        mcnt          = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                mcnt++;
                if (!mem_hang && mcnt == mem_lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                end
            end else begin
                mcnt          = 0;
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
        end
    end

    // Monitor: compares every grant and response against the queues.
    initial begin
        gnt_t g;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.if_gnt && bus.dm_gnt)
                    fail_event("dual_gnt", "got both gnt, required one");
                if (bus.if_gnt || bus.dm_gnt) begin
                    if (gq.size() == 0) begin
                        fail_event("unexpected_gnt", "got gnt, required none");
                    end else begin
                        g = gq.pop_front();
                        check("gnt_owner_dm", 64'(bus.dm_gnt), 64'(g.is_dm));
                        check("gnt_mem_req",  64'(bus.mem_req), 64'd1);
                        check("gnt_mem_addr", bus.mem_addr, g.addr);
                        check("gnt_mem_we",   64'(bus.mem_we), 64'(g.we));
                        check("gnt_mem_size", 64'(bus.mem_size), 64'(g.size));
                        check("gnt_mem_wdata", bus.mem_wdata, g.wdata);
                    end
                end
                if (bus.if_rvalid || bus.dm_rvalid) begin
                    if (rq.size() == 0) begin
                        fail_event("unexpected_rvalid", "got rvalid, required none");
                    end else begin
                        r = rq.pop_front();
                        check("rsp_owner_dm", 64'(bus.dm_rvalid), 64'(r.is_dm));
                        if (bus.dm_rvalid) begin
                            check("dm_rdata", bus.dm_rdata, r.rdata);
                            check("dm_err", 64'(bus.dm_err), 64'(r.err));
                        end else begin
                            check("if_rdata", 64'(bus.if_rdata), r.rdata);
                            check("if_err", 64'(bus.if_err), 64'(r.err));
                        end
                    end
                end
            end
        end
    end

    // One cycle of the requesters: drop a request once all wanted accesses
    // have been granted.
    task automatic step();
        @(negedge clk);
        if (bus.if_gnt && if_left > 0) if_left--;
        if (bus.dm_gnt && dm_left > 0) dm_left--;
        bus.if_req = (if_left > 0);
        bus.dm_req = (dm_left > 0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(if_left == 0 && dm_left == 0 && gq.size() == 0 &&
                 rq.size() == 0 && !bus.mem_req) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget)
            fail_event(name, "bound expired, required all responses");
        step();
    endtask

    task automatic push_if(input logic [63:0] addr, input logic [31:0] data);
        gq.push_back('{is_dm: 1'b0, addr: addr, we: 1'b0, size: 2'b10, wdata: 64'd0});
        rq.push_back('{is_dm: 1'b0, err: 1'b0, rdata: 64'(data)});
    endtask

    task automatic push_dm(input logic [63:0] addr, input bit we, input logic [1:0] size,
                           input logic [63:0] wdata, input bit err, input logic [63:0] rdata);
        gq.push_back('{is_dm: 1'b1, addr: addr, we: we, size: size, wdata: wdata});
        rq.push_back('{is_dm: 1'b1, err: err, rdata: rdata});
    endtask

    initial begin
        int n;
        int high;
        bit seen;

        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_size  = '0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req",   64'(bus.mem_req), 64'd0);
        check("rst_gnts",      64'({bus.if_gnt, bus.dm_gnt}), 64'd0);
        check("rst_rvalids",   64'({bus.if_rvalid, bus.dm_rvalid, bus.if_err, bus.dm_err}), 64'd0);
        check("rst_mem_addr",  bus.mem_addr, 64'd0);
        check("rst_rdata",     bus.dm_rdata | 64'(bus.if_rdata), 64'd0);
        reset = 1'b1;
        step();

        // IF-only fetch with gnt latency and single-cycle pulse
        push_if(64'h40, 32'h00A0_0093);
        bus.if_addr = 64'h40;
        if_left = 1;
        step();
        step();
        check("if_gnt_latency", 64'(bus.if_gnt), 64'd1);
        step();
        check("if_gnt_pulse", 64'(bus.if_gnt), 64'd0);
        wait_done("wait_if_only", 20);

        // Simultaneous requests: DM load first, then IF
        push_dm(64'h1000, 1'b0, 2'b11, 64'd0, 1'b0, 64'h1122_3344_5566_7788);
        push_if(64'h44, 32'h00B0_0113);
        bus.if_addr  = 64'h44;
        bus.dm_we    = 1'b0;
        bus.dm_size  = 2'b11;
        bus.dm_addr  = 64'h1000;
        bus.dm_wdata = 64'd0;
        if_left = 1;
        dm_left = 1;
        wait_done("wait_priority", 40);

        // Response data holds while rvalid is low
        repeat (3) step();
        check("dm_rdata_hold", bus.dm_rdata, 64'h1122_3344_5566_7788);
        check("if_rdata_hold", 64'(bus.if_rdata), 64'h00B0_0113);

        // Store ack
        push_dm(64'h3000, 1'b1, 2'b00, 64'hAB, 1'b0, 64'd0);
        bus.dm_we    = 1'b1;
        bus.dm_size  = 2'b00;
        bus.dm_addr  = 64'h3000;
        bus.dm_wdata = 64'hAB;
        dm_left = 1;
        wait_done("wait_store", 20);

        // Starvation: 4 DM wins, forced IF win, counter restarts from 0
        for (int i = 0; i < 4; i++)
            push_dm(64'h2000, 1'b1, 2'b10, 64'h55, 1'b0, 64'd0);
        push_if(64'h48, 32'h0000_0513);
        for (int i = 0; i < 2; i++)
            push_dm(64'h2000, 1'b1, 2'b10, 64'h55, 1'b0, 64'd0);
        push_if(64'h48, 32'h0000_0513);
        bus.if_addr  = 64'h48;
        bus.dm_we    = 1'b1;
        bus.dm_size  = 2'b10;
        bus.dm_addr  = 64'h2000;
        bus.dm_wdata = 64'h55;
        if_left = 2;
        dm_left = 6;
        wait_done("wait_starve", 100);

        // Timeout: mem_req held exactly 64 cycles, error response
        mem_hang = 1'b1;
        push_dm(64'h1008, 1'b0, 2'b11, 64'd0, 1'b1, 64'd0);
        bus.dm_we    = 1'b0;
        bus.dm_size  = 2'b11;
        bus.dm_addr  = 64'h1008;
        bus.dm_wdata = 64'd0;
        dm_left = 1;
        n = 0;
        high = 0;
        seen = 1'b0;
        while (n < 300 && !(seen && !bus.mem_req)) begin
            step();
            n++;
            if (bus.mem_req) begin
                high++;
                seen = 1'b1;
            end
        end
        check("tmo_mem_req_cycles", 64'(high), 64'd64);
        wait_done("wait_timeout", 10);

        // Normal service after a timeout
        mem_hang = 1'b0;
        push_dm(64'h1008, 1'b0, 2'b11, 64'd0, 1'b0, 64'h0F0E_0D0C_0B0A_0908);
        dm_left = 1;
        wait_done("wait_after_tmo", 20);

        // Asynchronous reset in the middle of a hung access
        mem_hang = 1'b1;
        gq.push_back('{is_dm: 1'b1, addr: 64'h1000, we: 1'b0, size: 2'b11, wdata: 64'd0});
        bus.dm_addr = 64'h1000;
        dm_left = 1;
        repeat (5) step();
        check("pre_rst_mem_req", 64'(bus.mem_req), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("async_rst_pulses",
              64'({bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid}), 64'd0);
        check("async_rst_mem_addr", bus.mem_addr, 64'd0);
        dm_left = 0;
        bus.dm_req = 1'b0;
        mem_hang = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (5) step();
        check("post_rst_idle", 64'(bus.mem_req), 64'd0);

        // Fetch served normally after reset
        push_if(64'h40, 32'h00A0_0093);
        bus.if_addr = 64'h40;
        if_left = 1;
        wait_done("wait_after_rst", 20);

        check("gnt_queue_drained", 64'(gq.size()), 64'd0);
        check("rsp_queue_drained", 64'(rq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
